// File: rtl/mem_access_arb.sv
// Arbitrates one RAM between an init/loader channel and NUM_CH round-robin user channels.
// Optional power-on RAM clear is enabled by defining MEM_ACCESS_ARB_CLEAR_EN.
module mem_access_arb #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           init_req_i,
    input  logic                           init_we_i,
    input  logic [ADDR_WIDTH-3:0]          init_addr_i,
    input  logic [DATA_WIDTH-1:0]          init_wdata_i,
    output logic                           init_gnt_o,
    output logic                           init_rvalid_o,
    output logic [DATA_WIDTH-1:0]          init_rdata_o,
    input  logic                           init_done_i,
    input  logic                           init_start_i,
    input  logic [NUM_CH-1:0]              usr_req_i,
    input  logic [NUM_CH-1:0]              usr_we_i,
    input  logic [NUM_CH*(ADDR_WIDTH-2)-1:0] usr_addr_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   usr_wdata_i,
    output logic [NUM_CH-1:0]              usr_gnt_o,
    output logic [NUM_CH-1:0]              usr_rvalid_o,
    output logic [DATA_WIDTH-1:0]          usr_rdata_o,
    output logic                           user_mode_o,
`ifdef MEM_ACCESS_ARB_CLEAR_EN
    output logic                           clear_busy_o,
`endif
    output logic                           rd_en_o,
    output logic                           wr_en_o,
    output logic [ADDR_WIDTH-3:0]          raddr_o,
    output logic [ADDR_WIDTH-3:0]          waddr_o,
    output logic [DATA_WIDTH-1:0]          wdata_o,
    input  logic [DATA_WIDTH-1:0]          rdata_i
);

    localparam int unsigned AW = ADDR_WIDTH - 2;
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {StInit, StDrainU, StUser, StDrainI, StClear} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         ptr_q, ptr_d;
    logic                  rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [AW-1:0]         raddr_q, raddr_d, waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    // Read-tag pipeline: stage k holds the read issued k+1 cycles ago.
    logic [RD_LATENCY:0]   tag_vld_q, tag_init_q;
    logic [CW-1:0]         tag_ch_q [RD_LATENCY+1];
    logic                  tag_in_vld, tag_in_init;
    logic [CW-1:0]         tag_in_ch;
    logic                  pipe_busy;

    logic                  usr_found;
    logic [CW-1:0]         usr_sel;

`ifdef MEM_ACCESS_ARB_CLEAR_EN
    logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
    assign clear_busy_o = (state_q == StClear);
`endif

    assign pipe_busy    = |tag_vld_q;
    assign user_mode_o  = (state_q == StUser);
    assign init_rdata_o = rdata_i;
    assign usr_rdata_o  = rdata_i;
    assign rd_en_o      = rd_en_q;
    assign wr_en_o      = wr_en_q;
    assign raddr_o      = raddr_q;
    assign waddr_o      = waddr_q;
    assign wdata_o      = wdata_q;
    assign init_rvalid_o = tag_vld_q[RD_LATENCY] & tag_init_q[RD_LATENCY];

    always_comb begin
        usr_rvalid_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (tag_vld_q[RD_LATENCY] && !tag_init_q[RD_LATENCY] &&
                tag_ch_q[RD_LATENCY] == CW'(c)) begin
                usr_rvalid_o[c] = 1'b1;
            end
        end
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        logic [CW-1:0] idx;
        usr_found = 1'b0;
        usr_sel   = ptr_q;
        idx       = ptr_q;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (idx == CW'(NUM_CH - 1)) ? '0 : idx + 1'b1;
            if (!usr_found && usr_req_i[idx]) begin
                usr_found = 1'b1;
                usr_sel   = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        init_gnt_o  = 1'b0;
        usr_gnt_o   = '0;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        raddr_d     = raddr_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        tag_in_vld  = 1'b0;
        tag_in_init = 1'b0;
        tag_in_ch   = '0;
`ifdef MEM_ACCESS_ARB_CLEAR_EN
        clr_cnt_d   = clr_cnt_q;
`endif
        case (state_q)
            StInit: begin
                if (init_req_i) begin
                    init_gnt_o  = 1'b1;
                    tag_in_init = 1'b1;
                    if (init_we_i) begin
                        wr_en_d = 1'b1;
                        waddr_d = init_addr_i;
                        wdata_d = init_wdata_i;
                    end else begin
                        rd_en_d    = 1'b1;
                        raddr_d    = init_addr_i;
                        tag_in_vld = 1'b1;
                    end
                end
                if (init_done_i) state_d = StDrainU;
            end
            StDrainU: if (!pipe_busy) state_d = StUser;
            StUser: begin
                if (init_start_i) begin
                    state_d = StDrainI;
                end else if (usr_found) begin
                    usr_gnt_o[usr_sel] = 1'b1;
                    ptr_d              = usr_sel;
                    tag_in_ch          = usr_sel;
                    if (usr_we_i[usr_sel]) begin
                        wr_en_d = 1'b1;
                        waddr_d = usr_addr_i[usr_sel*AW +: AW];
                        wdata_d = usr_wdata_i[usr_sel*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        rd_en_d    = 1'b1;
                        raddr_d    = usr_addr_i[usr_sel*AW +: AW];
                        tag_in_vld = 1'b1;
                    end
                end
            end
            StDrainI: if (!pipe_busy) state_d = StInit;
`ifdef MEM_ACCESS_ARB_CLEAR_EN
            StClear: begin
                wr_en_d   = 1'b1;
                waddr_d   = clr_cnt_q;
                wdata_d   = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) state_d = StInit;
            end
`endif
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef MEM_ACCESS_ARB_CLEAR_EN
            state_q   <= StClear;
            clr_cnt_q <= '0;
`else
            state_q   <= StInit;
`endif
            ptr_q      <= CW'(NUM_CH - 1);
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            raddr_q    <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            tag_vld_q  <= '0;
            tag_init_q <= '0;
            for (int k = 0; k <= RD_LATENCY; k++) tag_ch_q[k] <= '0;
        end else begin
            state_q    <= state_d;
`ifdef MEM_ACCESS_ARB_CLEAR_EN
            clr_cnt_q  <= clr_cnt_d;
`endif
            ptr_q      <= ptr_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            raddr_q    <= raddr_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            tag_vld_q  <= {tag_vld_q[RD_LATENCY-1:0], tag_in_vld};
            tag_init_q <= {tag_init_q[RD_LATENCY-1:0], tag_in_init};
            tag_ch_q[0] <= tag_in_ch;
            for (int k = 1; k <= RD_LATENCY; k++) tag_ch_q[k] <= tag_ch_q[k-1];
        end
    end

endmodule

// File: tb/tb_mem_access_arb.sv
// Directed bench for mem_access_arb with a latency-1 RAM model (default parameters).
module tb_mem_access_arb;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          init_req, init_we, init_gnt, init_rvalid, init_done, init_start;
    logic [AW-1:0] init_addr;
    logic [DW-1:0] init_wdata, init_rdata;
    logic [1:0]    usr_req, usr_we, usr_gnt, usr_rvalid;
    logic [2*AW-1:0] usr_addr;
    logic [2*DW-1:0] usr_wdata;
    logic [DW-1:0] usr_rdata;
    logic          user_mode, rd_en, wr_en;
    logic [AW-1:0] raddr, waddr;
    logic [DW-1:0] wdata, rdata;
`ifdef MEM_ACCESS_ARB_CLEAR_EN
    logic          clear_busy;
`endif

    logic [DW-1:0] mem [64];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) mem[waddr] <= wdata;
        if (rd_en) rdata <= mem[raddr];
    end

    mem_access_arb dut (
        .clk          (clk),
        .reset        (reset),
        .init_req_i   (init_req),
        .init_we_i    (init_we),
        .init_addr_i  (init_addr),
        .init_wdata_i (init_wdata),
        .init_gnt_o   (init_gnt),
        .init_rvalid_o(init_rvalid),
        .init_rdata_o (init_rdata),
        .init_done_i  (init_done),
        .init_start_i (init_start),
        .usr_req_i    (usr_req),
        .usr_we_i     (usr_we),
        .usr_addr_i   (usr_addr),
        .usr_wdata_i  (usr_wdata),
        .usr_gnt_o    (usr_gnt),
        .usr_rvalid_o (usr_rvalid),
        .usr_rdata_o  (usr_rdata),
        .user_mode_o  (user_mode),
`ifdef MEM_ACCESS_ARB_CLEAR_EN
        .clear_busy_o (clear_busy),
`endif
        .rd_en_o      (rd_en),
        .wr_en_o      (wr_en),
        .raddr_o      (raddr),
        .waddr_o      (waddr),
        .wdata_o      (wdata),
        .rdata_i      (rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; init_req = 0; init_we = 0; init_addr = '0; init_wdata = '0;
        init_done = 0; init_start = 0; usr_req = '0; usr_we = '0; usr_addr = '0;
        usr_wdata = '0;
        step(); step();
        #1;
        total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en got %b want 0", rd_en); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got %b want 0", wr_en); end
        total++; if (raddr !== 6'd0) begin bad++; $display("FAIL rst_raddr got %h want 0", raddr); end
        total++; if (waddr !== 6'd0) begin bad++; $display("FAIL rst_waddr got %h want 0", waddr); end
        total++; if (wdata !== 8'd0) begin bad++; $display("FAIL rst_wdata got %h want 0", wdata); end
        total++; if (usr_rvalid !== 2'b00) begin bad++; $display("FAIL rst_usr_rvalid got %b want 00", usr_rvalid); end
        total++; if (init_rvalid !== 1'b0) begin bad++; $display("FAIL rst_init_rvalid got %b want 0", init_rvalid); end
        total++; if (user_mode !== 1'b0) begin bad++; $display("FAIL rst_user_mode got %b want 0", user_mode); end
        reset = 1'b0;
    endtask

`ifdef MEM_ACCESS_ARB_CLEAR_EN
    task automatic test_clear();
        int n = 0;
        total++; if (clear_busy !== 1'b1) begin bad++; $display("FAIL clr_busy_on got %b want 1", clear_busy); end
        for (int i = 0; i < 80 && n < 64; i++) begin
            step();
            if (wr_en) begin
                total++;
                if (waddr !== 6'(n) || wdata !== 8'd0) begin
                    bad++; $display("FAIL clr_write got %h/%h want %h/00", waddr, wdata, 6'(n));
                end
                n++;
            end
        end
        total++; if (n != 64) begin bad++; $display("FAIL clr_count got %0d want 64", n); end
        total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL clr_busy_off got %b want 0", clear_busy); end
        step();
    endtask
`endif

    task automatic test_init_write();
        init_req = 1; init_we = 1; init_addr = 6'h05; init_wdata = 8'hA5;
        #1;
        total++; if (init_gnt !== 1'b1) begin bad++; $display("FAIL iw_gnt got %b want 1", init_gnt); end
        total++; if (usr_gnt !== 2'b00) begin bad++; $display("FAIL iw_usr_gnt got %b want 00", usr_gnt); end
        step();
        init_req = 0;
        #1;
        total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL iw_wr_en got %b want 1", wr_en); end
        total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL iw_rd_en got %b want 0", rd_en); end
        total++; if (waddr !== 6'h05) begin bad++; $display("FAIL iw_waddr got %h want 05", waddr); end
        total++; if (wdata !== 8'hA5) begin bad++; $display("FAIL iw_wdata got %h want a5", wdata); end
        step();
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL iw_wr_off got %b want 0", wr_en); end
    endtask

    task automatic test_init_read();
        init_req = 1; init_we = 0; init_addr = 6'h05;
        #1;
        total++; if (init_gnt !== 1'b1) begin bad++; $display("FAIL ir_gnt got %b want 1", init_gnt); end
        step();
        init_req = 0;
        #1;
        total++; if (rd_en !== 1'b1 || raddr !== 6'h05) begin bad++; $display("FAIL ir_rd got %b/%h want 1/05", rd_en, raddr); end
        total++; if (init_rvalid !== 1'b0) begin bad++; $display("FAIL ir_early got %b want 0", init_rvalid); end
        step();
        total++; if (init_rvalid !== 1'b1) begin bad++; $display("FAIL ir_rvalid got %b want 1", init_rvalid); end
        total++; if (init_rdata !== 8'hA5) begin bad++; $display("FAIL ir_rdata got %h want a5", init_rdata); end
        step();
        total++; if (init_rvalid !== 1'b0) begin bad++; $display("FAIL ir_rvalid_off got %b want 0", init_rvalid); end
    endtask

    task automatic test_handover();
        init_req = 1; init_we = 0; init_addr = 6'h05; init_done = 1;
        #1;
        total++; if (init_gnt !== 1'b1) begin bad++; $display("FAIL ho_gnt got %b want 1", init_gnt); end
        step();
        init_done = 0; usr_req = 2'b11; usr_we = 2'b00;
        #1;
        total++; if (init_gnt !== 1'b0 || usr_gnt !== 2'b00) begin bad++; $display("FAIL ho_drain1 got %b/%b want 0/00", init_gnt, usr_gnt); end
        total++; if (rd_en !== 1'b1) begin bad++; $display("FAIL ho_rd_en got %b want 1", rd_en); end
        step();
        total++; if (init_gnt !== 1'b0 || usr_gnt !== 2'b00) begin bad++; $display("FAIL ho_drain2 got %b/%b want 0/00", init_gnt, usr_gnt); end
        total++; if (init_rvalid !== 1'b1 || init_rdata !== 8'hA5) begin bad++; $display("FAIL ho_rvalid got %b/%h want 1/a5", init_rvalid, init_rdata); end
        step();
        total++; if (usr_gnt !== 2'b00 || user_mode !== 1'b0) begin bad++; $display("FAIL ho_drain3 got %b/%b want 00/0", usr_gnt, user_mode); end
        step();
        usr_req = 2'b00;
        #1;
        total++; if (user_mode !== 1'b1) begin bad++; $display("FAIL ho_user_mode got %b want 1", user_mode); end
        total++; if (init_gnt !== 1'b0) begin bad++; $display("FAIL ho_init_ignored got %b want 0", init_gnt); end
        init_req = 0;
    endtask

    task automatic test_round_robin();
        usr_req = 2'b11; usr_we = 2'b11;
        usr_addr = {6'd20, 6'd10}; usr_wdata = {8'h22, 8'h11};
        #1;
        total++; if (usr_gnt !== 2'b01) begin bad++; $display("FAIL rr_gnt0 got %b want 01", usr_gnt); end
        step();
        total++; if (usr_gnt !== 2'b10) begin bad++; $display("FAIL rr_gnt1 got %b want 10", usr_gnt); end
        total++; if (wr_en !== 1'b1 || waddr !== 6'd10 || wdata !== 8'h11) begin bad++; $display("FAIL rr_wr0 got %b/%h/%h want 1/0a/11", wr_en, waddr, wdata); end
        step();
        usr_we = 2'b00; usr_addr = {6'd10, 6'd20};
        #1;
        total++; if (usr_gnt !== 2'b01) begin bad++; $display("FAIL rr_gnt2 got %b want 01", usr_gnt); end
        total++; if (wr_en !== 1'b1 || waddr !== 6'd20 || wdata !== 8'h22) begin bad++; $display("FAIL rr_wr1 got %b/%h/%h want 1/14/22", wr_en, waddr, wdata); end
        step();
        total++; if (usr_gnt !== 2'b10) begin bad++; $display("FAIL rr_gnt3 got %b want 10", usr_gnt); end
        total++; if (rd_en !== 1'b1 || wr_en !== 1'b0 || raddr !== 6'd20) begin bad++; $display("FAIL rr_rd0 got %b/%b/%h want 1/0/14", rd_en, wr_en, raddr); end
        total++; if (usr_rvalid !== 2'b00) begin bad++; $display("FAIL rr_rv_early got %b want 00", usr_rvalid); end
        step();
        usr_req = 2'b00;
        #1;
        total++; if (usr_gnt !== 2'b00) begin bad++; $display("FAIL rr_idle got %b want 00", usr_gnt); end
        total++; if (rd_en !== 1'b1 || raddr !== 6'd10) begin bad++; $display("FAIL rr_rd1 got %b/%h want 1/0a", rd_en, raddr); end
        total++; if (usr_rvalid !== 2'b01 || usr_rdata !== 8'h22) begin bad++; $display("FAIL rr_rv0 got %b/%h want 01/22", usr_rvalid, usr_rdata); end
        total++; if (init_rvalid !== 1'b0) begin bad++; $display("FAIL rr_init_rv got %b want 0", init_rvalid); end
        step();
        total++; if (usr_rvalid !== 2'b10 || usr_rdata !== 8'h11) begin bad++; $display("FAIL rr_rv1 got %b/%h want 10/11", usr_rvalid, usr_rdata); end
        step();
        total++; if (usr_rvalid !== 2'b00) begin bad++; $display("FAIL rr_rv_off got %b want 00", usr_rvalid); end
    endtask

    task automatic test_init_start();
        usr_req = 2'b01; usr_we = 2'b00; usr_addr = {6'd0, 6'd10};
        #1;
        total++; if (usr_gnt !== 2'b01) begin bad++; $display("FAIL is_gnt got %b want 01", usr_gnt); end
        step();
        init_start = 1; init_req = 1; init_we = 0; init_addr = 6'h05;
        #1;
        total++; if (usr_gnt !== 2'b00 || init_gnt !== 1'b0) begin bad++; $display("FAIL is_nogrant got %b/%b want 00/0", usr_gnt, init_gnt); end
        total++; if (user_mode !== 1'b1 || rd_en !== 1'b1 || raddr !== 6'd10) begin bad++; $display("FAIL is_rd got %b/%b/%h want 1/1/0a", user_mode, rd_en, raddr); end
        step();
        init_start = 0; usr_req = 2'b00;
        #1;
        total++; if (user_mode !== 1'b0 || init_gnt !== 1'b0) begin bad++; $display("FAIL is_drain got %b/%b want 0/0", user_mode, init_gnt); end
        total++; if (usr_rvalid !== 2'b01 || usr_rdata !== 8'h11) begin bad++; $display("FAIL is_rv got %b/%h want 01/11", usr_rvalid, usr_rdata); end
        step();
        total++; if (init_gnt !== 1'b0 || usr_rvalid !== 2'b00) begin bad++; $display("FAIL is_drain2 got %b/%b want 0/00", init_gnt, usr_rvalid); end
        step();
        total++; if (init_gnt !== 1'b1 || user_mode !== 1'b0) begin bad++; $display("FAIL is_init_gnt got %b/%b want 1/0", init_gnt, user_mode); end
        step();
        init_req = 0;
        #1;
        total++; if (rd_en !== 1'b1 || raddr !== 6'h05) begin bad++; $display("FAIL is_init_rd got %b/%h want 1/05", rd_en, raddr); end
        step();
        total++; if (init_rvalid !== 1'b1 || init_rdata !== 8'hA5) begin bad++; $display("FAIL is_init_rv got %b/%h want 1/a5", init_rvalid, init_rdata); end
    endtask

    initial begin
        test_reset();
`ifdef MEM_ACCESS_ARB_CLEAR_EN
        test_clear();
`endif
        test_init_write();
        test_init_read();
        test_handover();
        test_round_robin();
        test_init_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
